// File: rtl/sram_banked_pkg.sv
// Shared types and helpers for the banked SRAM buffer.
// Optional SRAM_OUT_REG_EN adds an output register stage (latency 2).
package sram_pkg;

    localparam int DEF_DATA_WIDTH = 12;
    localparam int DEF_ADDR_WIDTH = 11;
    localparam int DEF_NUM_BANKS  = 4;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    function automatic int unsigned bsel_of(input int unsigned nb);
        return $clog2(nb);
    endfunction

    function automatic int unsigned depth_of(input int unsigned aw,
                                             input int unsigned nb);
        return (32'd1 << aw) / nb;
    endfunction

    // Bank index is the low-order address bits (nb is a power of two).
    function automatic int unsigned bank_of(input int unsigned addr,
                                            input int unsigned nb);
        return addr & (nb - 1);
    endfunction

    localparam int BSEL       = bsel_of(DEF_NUM_BANKS);
    localparam int BANK_DEPTH = depth_of(DEF_ADDR_WIDTH, DEF_NUM_BANKS);

endpackage

// File: rtl/sram_banked_if.sv
// Write/read request and read response bundle for sram_banked.
// master = requester, slave = the buffer.
interface sram_banked_if #(
    parameter int AW = 11,
    parameter int DW = 12
);
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;

    modport master (
        output wr_valid, wr_addr, wr_data,
        output rd_valid, rd_addr,
        input  wr_ready, rd_ready,
        input  rsp_valid, rsp_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        input  rd_valid, rd_addr,
        output wr_ready, rd_ready,
        output rsp_valid, rsp_data
    );
endinterface

// File: rtl/sram_banked_bank_1p.sv
// Single-port bank: one read or one write per cycle.
// Read data is registered and held until the next read.
module sram_bank_1p #(
    parameter int DW    = 12,
    parameter int DEPTH = 512,
    parameter int RW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          we,
    input  logic [RW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);
    logic [DW-1:0] mem [DEPTH];

    // Storage array write port
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= din;
        end
    end

    // Registered read data, held while the bank is not read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (en && !we) begin
            dout <= mem[addr];
        end
    end
endmodule

// File: rtl/sram_banked.sv
// Low-order interleaved multi-bank buffer with clear engine.
// SRAM_OUT_REG_EN: extra output register after the bank mux.
module sram_banked
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_BANKS  = DEF_NUM_BANKS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    output logic        init_done,
    sram_banked_if.slave bus
);
    localparam int BS    = bsel_of(NUM_BANKS);
    localparam int DEPTH = depth_of(ADDR_WIDTH, NUM_BANKS);
    localparam int RW    = ADDR_WIDTH - BS;

    localparam logic [0:0] S_CLEAR = CLEAR;
    localparam logic [0:0] S_READY = READY;

    logic [0:0]            state;
    logic [RW-1:0]         row_cnt;
    logic                  clearing;
    logic                  conflict;
    logic                  wr_fire;
    logic                  rd_fire;
    logic [BS-1:0]         wr_bank;
    logic [BS-1:0]         rd_bank;
    logic [RW-1:0]         wr_row;
    logic [RW-1:0]         rd_row;
    logic [BS-1:0]         rd_bank_q;
    logic                  rsp_v1;
    logic [DATA_WIDTH-1:0] rsp_d1;
    logic [DATA_WIDTH-1:0] bank_dout [NUM_BANKS];

    assign clearing  = (state == S_CLEAR);
    assign init_done = (state == S_READY);

    assign wr_bank = bus.wr_addr[BS-1:0];
    assign rd_bank = bus.rd_addr[BS-1:0];
    assign wr_row  = bus.wr_addr[ADDR_WIDTH-1:BS];
    assign rd_row  = bus.rd_addr[ADDR_WIDTH-1:BS];

    assign conflict = bus.wr_valid &&
        (bank_of(32'(bus.wr_addr), NUM_BANKS) ==
         bank_of(32'(bus.rd_addr), NUM_BANKS));

    assign bus.wr_ready = init_done && !clr;
    assign bus.rd_ready = init_done && !clr && !conflict;

    assign wr_fire = bus.wr_valid && bus.wr_ready;
    assign rd_fire = bus.rd_valid && bus.rd_ready;

    // Clear engine sweeps every row once, then hands over to READY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_CLEAR;
            row_cnt <= '0;
        end else begin
            unique case (state)
                S_CLEAR: begin
                    row_cnt <= row_cnt + 1'b1;
                    if (row_cnt == RW'(DEPTH - 1)) begin
                        state <= S_READY;
                    end
                end
                S_READY: begin
                    if (clr) begin
                        state   <= S_CLEAR;
                        row_cnt <= '0;
                    end
                end
                default: begin
                    state   <= S_CLEAR;
                    row_cnt <= '0;
                end
            endcase
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic                  wr_hit;
        logic                  rd_hit;
        logic                  en;
        logic                  we;
        logic [RW-1:0]         addr;
        logic [DATA_WIDTH-1:0] din;

        // Clear writes zeros everywhere; otherwise the write owns the bank
        always_comb begin
            wr_hit = wr_fire && (wr_bank == BS'(b));
            rd_hit = rd_fire && (rd_bank == BS'(b));
            en     = wr_hit || rd_hit;
            we     = wr_hit;
            addr   = wr_hit ? wr_row : rd_row;
            din    = bus.wr_data;
            if (clearing) begin
                en   = 1'b1;
                we   = 1'b1;
                addr = row_cnt;
                din  = '0;
            end
        end

        sram_bank_1p #(
            .DW    (DATA_WIDTH),
            .DEPTH (DEPTH),
            .RW    (RW)
        ) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .we    (we),
            .addr  (addr),
            .din   (din),
            .dout  (bank_dout[b])
        );
    end

    // Track which bank answers the read issued last cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_v1    <= 1'b0;
            rd_bank_q <= '0;
        end else begin
            rsp_v1 <= rd_fire;
            if (rd_fire) begin
                rd_bank_q <= rd_bank;
            end
        end
    end

    assign rsp_d1 = bank_dout[rd_bank_q];

`ifdef SRAM_OUT_REG_EN
    logic                  rsp_v2;
    logic [DATA_WIDTH-1:0] rsp_d2;

    // Output stage: valid and data move together, data held between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_v2 <= 1'b0;
            rsp_d2 <= '0;
        end else begin
            rsp_v2 <= rsp_v1;
            if (rsp_v1) begin
                rsp_d2 <= rsp_d1;
            end
        end
    end

    assign bus.rsp_valid = rsp_v2;
    assign bus.rsp_data  = rsp_d2;
`else
    assign bus.rsp_valid = rsp_v1;
    assign bus.rsp_data  = rsp_d1;
`endif
endmodule

// File: tb/tb_sram_banked.sv
// Testbench for sram_banked: vector table plus read scoreboard.
// Honours SRAM_OUT_REG_EN for the expected read latency.
module tb_sram_banked;
    import sram_pkg::*;

`ifdef SRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;
    logic init_done;

    sram_banked_if #(.AW(11), .DW(12)) bus ();

    sram_banked dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .init_done (init_done),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    int tests   = 0;
    int fails   = 0;
    int cyc     = 0;
    int rsp_cnt = 0;

    logic [11:0] model [2048];

    typedef struct {
        logic [11:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          wv;
        logic [10:0] wa;
        logic [11:0] wd;
        bit          rv;
        logic [10:0] ra;
        bit          ewr;
        bit          erd;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Scoreboard: check responses, queue new reads, apply writes to model
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.rsp_valid) begin
                rsp_cnt++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rsp: got data %0h expected none (cycle %0d)",
                             bus.rsp_data, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                    chk("rsp_cycle", cyc, e.due);
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                tests++;
                fails++;
                $display("FAIL missing_rsp: got no rsp_valid expected data %0h (cycle %0d)",
                         sb[0].data, cyc);
                void'(sb.pop_front());
            end
            if (bus.rd_valid && bus.rd_ready) begin
                sb.push_back('{model[bus.rd_addr], cyc + LAT});
            end
            if (bus.wr_valid && bus.wr_ready) begin
                model[bus.wr_addr] = bus.wr_data;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit wv, input logic [10:0] wa,
                         input logic [11:0] wd, input bit rv,
                         input logic [10:0] ra);
        bus.wr_valid = wv;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        bus.rd_valid = rv;
        bus.rd_addr  = ra;
    endtask

    task automatic zero_model();
        for (int i = 0; i < 2048; i++) model[i] = '0;
    endtask

    // Count rising edges until init_done, checking ready stays low meanwhile
    task automatic wait_init(input string name);
        int n;
        int bad;
        n   = 0;
        bad = 0;
        while (!init_done && n < 2000) begin
            if (bus.wr_ready || bus.rd_ready) bad++;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk(name, n, 512);
        chk({name, "_ready_low"}, bad, 0);
    endtask

    task automatic drain(input string name);
        drive(0, '0, '0, 0, '0);
        repeat (LAT + 2) tick();
        chk(name, sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0;
        int bad;

        vecs[0] = '{1'b1, 11'd5, 12'h5A3, 1'b0, 11'd0, 1'b1, 1'b1};
        vecs[1] = '{1'b0, 11'd0, 12'h000, 1'b1, 11'd5, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 11'd0, 12'h000, 1'b1, 11'd6, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 11'd4, 12'h111, 1'b1, 11'd8, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 11'd0, 12'h000, 1'b1, 11'd8, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 11'd4, 12'h222, 1'b1, 11'd9, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 11'd0, 12'h000, 1'b1, 11'd4, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 11'd7, 12'h007, 1'b1, 11'd4, 1'b1, 1'b1};

        zero_model();
        drive(1, 11'd1, 12'hFFF, 1, 11'd2);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_init_done", init_done, 0);
        chk("rst_wr_ready", bus.wr_ready, 0);
        chk("rst_rd_ready", bus.rd_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 0);

        // Reset release: clear takes bank-depth cycles
        rst_n = 1'b1;
        wait_init("init_cycles");
        tick();
        drive(0, '0, '0, 0, '0);

        // Table of single-cycle vectors incl. bank conflict and retry
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].rv, vecs[i].ra);
            @(negedge clk);
            chk($sformatf("vec%0d_wr_ready", i), bus.wr_ready, vecs[i].ewr);
            chk($sformatf("vec%0d_rd_ready", i), bus.rd_ready, vecs[i].erd);
            tick();
        end
        drain("vec_drain");

        // Fill the whole array, then stream 2048 back-to-back reads
        bad = 0;
        for (int i = 0; i < 2048; i++) begin
            drive(1, 11'(i), 12'(i ^ 'h3FF), 0, '0);
            @(negedge clk);
            if (!bus.wr_ready) bad++;
            tick();
        end
        chk("fill_wr_ready", bad, 0);
        r0  = rsp_cnt;
        bad = 0;
        for (int i = 0; i < 2048; i++) begin
            drive(0, '0, '0, 1, 11'(i));
            @(negedge clk);
            if (!bus.rd_ready) bad++;
            tick();
        end
        chk("stream_rd_ready", bad, 0);
        drain("stream_drain");
        chk("stream_rsp_count", rsp_cnt - r0, 2048);

        // Clear request: ports closed in the clr cycle, array zeroed
        chk("pre_clr_init_done", init_done, 1);
        clr = 1'b1;
        drive(1, 11'd3, 12'hABC, 1, 11'd6);
        @(negedge clk);
        chk("clr_wr_ready", bus.wr_ready, 0);
        chk("clr_rd_ready", bus.rd_ready, 0);
        tick();
        clr = 1'b0;
        drive(0, '0, '0, 0, '0);
        zero_model();
        chk("clr_init_drop", init_done, 0);
        wait_init("clr_cycles");
        tick();
        for (int i = 0; i < 5; i++) begin
            logic [10:0] a;
            a = (i == 0) ? 11'd0 : (i == 1) ? 11'd5 : (i == 2) ? 11'd3 :
                (i == 3) ? 11'd2047 : 11'd1234;
            drive(0, '0, '0, 1, a);
            tick();
        end
        drain("clr_drain");

        // Reset with reads in flight
        for (int i = 0; i < 4; i++) begin
            drive(1, 11'(10 + i), 12'(12'h900 + i), 0, '0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, '0, 1, 11'(10 + i));
            tick();
        end
        rst_n = 1'b0;
        drive(0, '0, '0, 0, '0);
        #1;
        chk("midrst_rsp_valid", bus.rsp_valid, 0);
        chk("midrst_rsp_data", 32'(bus.rsp_data), 0);
        chk("midrst_init_done", init_done, 0);
        sb.delete();
        zero_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("rst2_cycles");
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, '0, 1, 11'(10 + i));
            tick();
        end
        drain("rst2_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
